// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// default address/instruction widths.
package instr_fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage : instr_fetch_unit_pkg

// File: rtl/instr_fetch_unit_fifo.sv
// instr_fifo: DEPTH-entry buffer of {pc,instr} pairs with push/pop/clear.
// Clear has priority over a same-cycle push and pop.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [0:W-1] wdata,
  output logic [0:W-1] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [0:W-1]  mem_q [DEPTH];
  logic [0:W-1]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          do_push,  do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  // A push at full is legal only when a pop frees the slot in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the storage array is reset too, so the head reads as zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only.
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : instr_fifo

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding imem requester feeding a small
// {pc,instr} buffer toward decode, with PC back-pressure and flush/redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = ADDR_W,
  parameter int DW    = INSTR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [0:AW-1] pc_in,
  output logic          pc_hold,
  output logic          imem_req,
  output logic [0:AW-1] imem_addr,
  input  logic          imem_ack,
  input  logic [0:DW-1] imem_rdata,
  input  logic          flush,
  output logic          if_valid,
  output logic [0:AW-1] if_pc,
  output logic [0:DW-1] if_instr,
  input  logic          id_ready
);

  fetch_state_e     state_q, state_d;
  logic             imem_req_q, imem_req_d;
  logic [0:AW-1]    imem_addr_q, imem_addr_d;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [0:AW+DW-1] fifo_head;

  always_comb begin
    state_d     = state_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    fifo_push   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Room is checked before issue, so the response always has a slot.
        if (!flush && !fifo_full) begin
          state_d     = ST_REQ;
          imem_req_d  = 1'b1;
          imem_addr_d = pc_in;
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          state_d    = ST_IDLE;
          imem_req_d = 1'b0;
          fifo_push  = !flush;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The stale request is never withdrawn; wait out its ack and drop it.
        if (imem_ack) begin
          state_d    = ST_IDLE;
          imem_req_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        imem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign pc_hold   = !(state_q == ST_REQ && imem_ack && !flush);
  assign if_valid  = !fifo_empty;
  assign fifo_pop  = if_valid & id_ready;
  assign if_pc     = fifo_head[0:AW-1];
  assign if_instr  = fifo_head[AW:AW+DW-1];

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (flush),
    .wdata ({imem_addr_q, imem_rdata}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule : instr_fetch_unit
